// File: rtl/manchester_serializer.sv
// Serializes one 16-symbol Manchester word MSB first, holding each half-bit symbol
// for CLKS_PER_HALFBIT clocks, then idles for GAP_HALFBITS half-bit periods.
module manchester_serializer #(
    parameter int unsigned CLKS_PER_HALFBIT = 4,
    parameter int unsigned GAP_HALFBITS     = 2,
    parameter logic        IDLE_LEVEL       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] CLK_MAX = 8'(CLKS_PER_HALFBIT - 1);
    localparam logic [3:0] GAP_MAX = 4'(GAP_HALFBITS - 1);

    state_t      state_q, state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [7:0]  clk_cnt_q, clk_cnt_d;
    logic [3:0]  sym_cnt_q, sym_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    // Next-state and datapath decode for the IDLE/SEND/GAP sequence
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        clk_cnt_d = clk_cnt_q;
        sym_cnt_d = sym_cnt_q;
        gap_cnt_d = gap_cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (word_valid) begin
                    shreg_d   = word_in;
                    tx_d      = word_in[15];
                    clk_cnt_d = 8'd0;
                    sym_cnt_d = 4'd0;
                    gap_cnt_d = 4'd0;
                    state_d   = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (clk_cnt_q == CLK_MAX) begin
                    clk_cnt_d = 8'd0;
                    if (sym_cnt_q != 4'd15) begin
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        tx_d      = shreg_q[14];
                        sym_cnt_d = sym_cnt_q + 4'd1;
                    end else begin
                        // Last symbol period ends: stop before sym_cnt can wrap
                        done_d    = 1'b1;
                        tx_d      = IDLE_LEVEL;
                        shreg_d   = 16'd0;
                        sym_cnt_d = 4'd0;
                        gap_cnt_d = 4'd0;
                        if (GAP_HALFBITS == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                tx_d = IDLE_LEVEL;
                if (clk_cnt_q == CLK_MAX) begin
                    clk_cnt_d = 8'd0;
                    if (gap_cnt_q == GAP_MAX) begin
                        gap_cnt_d = 4'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: begin
                tx_d    = IDLE_LEVEL;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= 16'd0;
            clk_cnt_q <= 8'd0;
            sym_cnt_q <= 4'd0;
            gap_cnt_q <= 4'd0;
            tx_q      <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            clk_cnt_q <= clk_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

    assign word_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign tx_out     = tx_q;
    assign done       = done_q;

endmodule
